// File: rtl/cdb_pkg.sv
// cdb_pkg: shared defaults and broadcast record for the common data bus.
package cdb_pkg;
  localparam int NUM_SRC_DEF = 4;
  localparam int TAG_W_DEF   = 4;
  localparam int DATA_W_DEF  = 32;
  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } cdb_bcast_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of one request, scanning upward from ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic          found;
  logic [PW-1:0] idx;
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: picks one functional-unit result per cycle and broadcasts it on the CDB.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [NUM_SRC-1:0]        cdb_grant,
  output logic [15:0]               bcast_count
);
  localparam int PW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  logic               valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [NUM_SRC-1:0] elig, gnt;
  logic [TAG_W-1:0]   sel_tag;
  logic [DATA_W-1:0]  sel_data;
  logic [PW-1:0]      ptr_nxt;
  logic               any;
  // The source on the bus now still shows valid until the next edge, so skip it.
  assign elig = src_valid & ~({NUM_SRC{valid_q}} & grant_q);
  rr_arbiter #(.N(NUM_SRC), .PW(PW)) u_rr (
    .req (elig),
    .ptr (ptr_q),
    .gnt (gnt)
  );
  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    ptr_nxt  = ptr_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_tag  |= gnt[i] ? src_tag[i*TAG_W +: TAG_W] : '0;
      sel_data |= gnt[i] ? src_data[i*DATA_W +: DATA_W] : '0;
      ptr_nxt   = gnt[i] ? PW'((i + 1) % NUM_SRC) : ptr_nxt;
    end
    any     = (|gnt) && !flush;
    valid_d = any;
    grant_d = any ? gnt : '0;
    tag_d   = any ? sel_tag : tag_q;
    data_d  = any ? sel_data : data_q;
    ptr_d   = flush ? '0 : ptr_nxt;
    cnt_d   = (valid_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign cdb_valid   = valid_q;
  assign cdb_tag     = tag_q;
  assign cdb_data    = data_q;
  assign cdb_grant   = grant_q;
  assign bcast_count = cnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench; a reference model queues the expected bus state per cycle.
module tb_cdb_arbiter;
  typedef struct packed {
    logic        valid;
    logic [3:0]  tag;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [15:0] cnt;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [15:0] src_tag;
  logic [127:0] src_data;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [3:0]  cdb_grant;
  logic [15:0] bcast_count;
  logic [3:0]  tag_a [4];
  logic [31:0] data_a [4];
  exp_t        m;
  int          m_ptr;
  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign src_tag[g*4 +: 4]   = tag_a[g];
    assign src_data[g*32 +: 32] = data_a[g];
  end
  cdb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .src_valid   (src_valid),
    .src_tag     (src_tag),
    .src_data    (src_data),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .cdb_grant   (cdb_grant),
    .bcast_count (bcast_count)
  );
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic [3:0] v, input logic fl, input bit cmp);
    exp_t       e;
    logic [3:0] el;
    int         p;
    bit         hit;
    src_valid = v;
    flush     = fl;
    el        = v & ~(m.valid ? m.grant : 4'b0);
    e         = m;
    e.valid   = 1'b0;
    e.grant   = '0;
    hit       = 0;
    if (fl) m_ptr = 0;
    else
      for (int k = 0; k < 4; k++) begin
        p = (m_ptr + k) % 4;
        if (!hit && el[p]) begin
          hit     = 1;
          e.valid = 1'b1;
          e.grant = 4'(1 << p);
          e.tag   = tag_a[p];
          e.data  = data_a[p];
          m_ptr   = (p + 1) % 4;
        end
      end
    if (e.valid && e.cnt != 16'hFFFF) e.cnt = e.cnt + 16'd1;
    m = e;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    if (cmp) begin
      chk("valid", 64'(cdb_valid), 64'(e.valid));
      chk("tag", 64'(cdb_tag), 64'(e.tag));
      chk("data", 64'(cdb_data), 64'(e.data));
      chk("grant", 64'(cdb_grant), 64'(e.grant));
      chk("count", 64'(bcast_count), 64'(e.cnt));
    end
    @(negedge clk);
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_valid"}, 64'(cdb_valid), 64'd0);
    chk({name, "_tag"}, 64'(cdb_tag), 64'd0);
    chk({name, "_data"}, 64'(cdb_data), 64'd0);
    chk({name, "_grant"}, 64'(cdb_grant), 64'd0);
    chk({name, "_count"}, 64'(bcast_count), 64'd0);
  endtask
  initial begin
    logic [3:0] rr_seq [5];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      tag_a[i]  = '0;
      data_a[i] = '0;
    end
    m     = '0;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    tag_a[0]  = 4'd3;
    data_a[0] = 32'h10;
    cyc(4'b0001, 1'b0, 1);
    chk("first_valid", 64'(cdb_valid), 64'd1);
    chk("first_tag", 64'(cdb_tag), 64'd3);
    chk("first_data", 64'(cdb_data), 64'h10);
    chk("first_grant", 64'(cdb_grant), 64'b0001);
    data_a[0] = 32'h99;
    cyc(4'b0001, 1'b0, 1);
    chk("masked_valid", 64'(cdb_valid), 64'd0);
    chk("masked_count", 64'(bcast_count), 64'd1);
    chk("hold_data", 64'(cdb_data), 64'h10);
    cyc(4'b0000, 1'b0, 1);
    cyc(4'b0000, 1'b1, 1);
    for (int i = 0; i < 4; i++) begin
      tag_a[i]  = 4'(i + 1);
      data_a[i] = 32'h100 + 32'(i);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 1'b0, 1);
      chk("rr_grant", 64'(cdb_grant), 64'(rr_seq[i]));
    end
    cyc(4'b0000, 1'b1, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0101, 1'b0, 1);
      chk("alt_valid", 64'(cdb_valid), 64'd1);
      chk("alt_tag", 64'(cdb_tag), (i % 2 == 0) ? 64'd1 : 64'd3);
    end
    cyc(4'b0010, 1'b1, 1);
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    chk("flush_grant", 64'(cdb_grant), 64'd0);
    cyc(4'b0010, 1'b0, 1);
    chk("post_flush_grant", 64'(cdb_grant), 64'b0010);
    cyc(4'b0000, 1'b0, 1);
    tag_a[2] = 4'd0;
    cyc(4'b0100, 1'b0, 1);
    chk("tag0_valid", 64'(cdb_valid), 64'd1);
    chk("tag0_tag", 64'(cdb_tag), 64'd0);
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 4; j++) begin
        tag_a[j]  = 4'($urandom);
        data_a[j] = $urandom;
      end
      cyc(4'($urandom_range(0, 15)), $urandom_range(0, 15) == 0, 1);
    end
    cyc(4'b0000, 1'b1, 1);
    cyc(4'b0001, 1'b0, 1);
    chk("pre_reset_valid", 64'(cdb_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    m     = '0;
    m_ptr = 0;
    @(negedge clk);
    reset = 1'b0;
    cyc(4'b1000, 1'b0, 1);
    cyc(4'b1111, 1'b0, 1);
    chk("reset_ptr_grant", 64'(cdb_grant), 64'b0001);
    for (int i = 0; i < 65540; i++) cyc(4'b0101, 1'b0, 0);
    chk("sat_count", 64'(bcast_count), 64'hFFFF);
    cyc(4'b0101, 1'b0, 1);
    cyc(4'b0101, 1'b0, 1);
    chk("sat_hold", 64'(bcast_count), 64'hFFFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
